// File: rtl/hud_pkg.sv
// -----------------------------------------------------------------------------
// hud_pkg
// Shared widths, constants and the conversion state type for the HUD
// binary-to-BCD stage.
//   HUD_BIN_W   : width of each binary value fed into the converter
//   HUD_DIGITS  : BCD digits presented on each output
//   HUD_ACC_W   : shift-add-3 accumulator width (one spare digit of headroom)
//   HUD_MAX_BCD : saturated display value
//   SPEED_MUL/SPEED_DIV : raw speed -> display units scale factor
//   DIST_LSB    : lowest distance bit kept when dropping sub-units
// -----------------------------------------------------------------------------
package hud_pkg;

  localparam int HUD_BIN_W    = 14;
  localparam int HUD_DIGITS   = 4;
  localparam int HUD_ACC_W    = 20;
  localparam int HUD_BCD_W    = 4 * HUD_DIGITS;
  localparam int HUD_NUM_VALS = 4;

  localparam logic [15:0] HUD_MAX_BCD = 16'h9999;

  localparam int SPEED_MUL   = 200;
  localparam int SPEED_DIV   = 513;
  localparam int DIST_LSB    = 6;
  localparam int DIST_KEEP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } hud_conv_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// One combinational shift-add-3 (double dabble) step.
// Ports:
//   i_acc : current BCD accumulator (5 digits)
//   i_bit : next binary bit, MSB first
//   o_acc : accumulator after digit correction and left shift
// -----------------------------------------------------------------------------
module bcd_dabble_step
  import hud_pkg::*;
(
  input  logic [HUD_ACC_W-1:0] i_acc,
  input  logic                 i_bit,
  output logic [HUD_ACC_W-1:0] o_acc
);

  // The top digit is never corrected: with at most 14 input bits it only
  // ever holds 0 or 1, so its MSB is always shifted out as zero.
  logic [HUD_ACC_W-2:0] w_adj;
  logic                 w_unused_msb;

  assign w_unused_msb = i_acc[HUD_ACC_W-1];

  always_comb begin
    w_adj = i_acc[HUD_ACC_W-2:0];
    for (int d = 0; d < HUD_DIGITS; d++) begin
      if (i_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign o_acc = {w_adj, i_bit};

endmodule

// File: rtl/hud_bcd_converter.sv
// -----------------------------------------------------------------------------
// hud_bcd_converter
// Per-frame snapshot of the HUD values, scaling to display units and
// sequential binary-to-BCD conversion (four values in parallel, one bit per
// cycle). Outputs only change on COMMIT, so a scan never sees torn digits.
// Ports:
//   clk, resetN      : clock, asynchronous active-low reset
//   frame_start      : one-cycle snapshot request (honoured in IDLE only)
//   fuel_val         : fuel, binary
//   score_val        : score, binary
//   player_speed     : raw speed, scaled by 200/513
//   distance_drove   : signed distance in sub-units (negative shows as 0)
//   fuel_bcd .. distance_bcd : 4-digit BCD, thousands in [15:12]
//   bcd_valid        : one-cycle pulse when the outputs update
//   busy             : conversion in flight
// Build option: define HUD_SATURATE_EN to clamp results above 9999 to 9999;
// otherwise the ten-thousands digit is dropped.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for frame_start, outputs holding last commit
// ST_CONVERT | 14 shift-add-3 steps on the captured snapshot
// ST_COMMIT  | load outputs from accumulators, pulse bcd_valid
// -----------------------------------------------------------------------------
module hud_bcd_converter
  import hud_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  frame_start,
  input  logic [HUD_BIN_W-1:0]  fuel_val,
  input  logic [HUD_BIN_W-1:0]  score_val,
  input  logic [9:0]            player_speed,
  input  logic [31:0]           distance_drove,
  output logic [HUD_BCD_W-1:0]  fuel_bcd,
  output logic [HUD_BCD_W-1:0]  score_bcd,
  output logic [HUD_BCD_W-1:0]  speed_bcd,
  output logic [HUD_BCD_W-1:0]  distance_bcd,
  output logic                  bcd_valid,
  output logic                  busy
);

  hud_conv_state_t      r_state;
  logic [3:0]           r_cnt;
  logic                 r_busy;
  logic                 r_bcd_valid;
  logic [HUD_BIN_W-1:0] r_bin [HUD_NUM_VALS];
  logic [HUD_ACC_W-1:0] r_acc [HUD_NUM_VALS];
  logic [HUD_BCD_W-1:0] r_out [HUD_NUM_VALS];

  logic [HUD_BIN_W-1:0] w_capture  [HUD_NUM_VALS];
  logic [HUD_ACC_W-1:0] w_acc_next [HUD_NUM_VALS];
  logic [HUD_BCD_W-1:0] w_commit   [HUD_NUM_VALS];

  // 10-bit speed times 200 fits 18 bits; quotient is at most 398.
  logic [17:0]          w_speed_prod;
  logic [17:0]          w_speed_quo;
  logic                 w_dist_neg;
  logic [HUD_BIN_W-1:0] w_dist_scaled;
  logic                 w_unused_in;

  assign w_speed_prod  = 18'(player_speed) * 18'(SPEED_MUL);
  assign w_speed_quo   = w_speed_prod / 18'(SPEED_DIV);
  assign w_dist_neg    = distance_drove[31];
  assign w_dist_scaled = w_dist_neg ? '0
                                    : HUD_BIN_W'(distance_drove[DIST_LSB +: DIST_KEEP_W]);
  assign w_unused_in   = ^{distance_drove[30:DIST_LSB+DIST_KEEP_W],
                           distance_drove[DIST_LSB-1:0],
                           w_speed_quo[17:HUD_BIN_W]};

  assign w_capture[0] = fuel_val;
  assign w_capture[1] = score_val;
  assign w_capture[2] = w_speed_quo[HUD_BIN_W-1:0];
  assign w_capture[3] = w_dist_scaled;

  for (genvar g = 0; g < HUD_NUM_VALS; g++) begin : g_val
    bcd_dabble_step u_step (
      .i_acc (r_acc[g]),
      .i_bit (r_bin[g][HUD_BIN_W-1]),
      .o_acc (w_acc_next[g])
    );

`ifdef HUD_SATURATE_EN
    assign w_commit[g] = (r_acc[g][HUD_ACC_W-1:HUD_BCD_W] != '0) ? HUD_MAX_BCD
                                                                  : r_acc[g][HUD_BCD_W-1:0];
`else
    logic w_unused_tt;
    assign w_unused_tt = ^r_acc[g][HUD_ACC_W-1:HUD_BCD_W];
    assign w_commit[g] = r_acc[g][HUD_BCD_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_bcd_valid <= 1'b0;
      for (int i = 0; i < HUD_NUM_VALS; i++) begin
        r_bin[i] <= '0;
        r_acc[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            for (int i = 0; i < HUD_NUM_VALS; i++) begin
              r_bin[i] <= w_capture[i];
              r_acc[i] <= '0;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          // The snapshot shifts left so its MSB is always the next bit in.
          for (int i = 0; i < HUD_NUM_VALS; i++) begin
            r_acc[i] <= w_acc_next[i];
            r_bin[i] <= r_bin[i] << 1;
          end
          if (r_cnt == 4'(HUD_BIN_W - 1)) begin
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < HUD_NUM_VALS; i++) begin
            r_out[i] <= w_commit[i];
          end
          r_bcd_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fuel_bcd     = r_out[0];
  assign score_bcd    = r_out[1];
  assign speed_bcd    = r_out[2];
  assign distance_bcd = r_out[3];
  assign bcd_valid    = r_bcd_valid;
  assign busy         = r_busy;

endmodule
